// File: rtl/rv_shift_fifo_rd.sv
// ----------------------------------------------------------------------------
// rv_shift_fifo_rd
//
// Shift-register FIFO whose read side is a valid/ready handshake. It is the
// reader-side partner of the enable-driven delay-line shift register and sits
// between SIMT pipeline stages where a short, cheap buffer is wanted and the
// downstream stage may stall.
//
// Writes always land in entries[0] and push the older contents up by one
// slot. The oldest word therefore sits at entries[count-1] and is driven
// combinationally on data_out, so a word written in cycle N appears on
// data_out in cycle N+1.
//
// Optional feature (macro RV_SHIFT_FIFO_BYPASS_EN):
//   When defined, an empty FIFO with in_valid = 1 presents data_in on
//   data_out in the same cycle. If the reader takes it, nothing is stored.
//   If the reader stalls, the word is stored as a normal write.
//   When undefined, an empty FIFO always presents out_valid = 0.
//
// Parameters:
//   DATAW   data width in bits
//   DEPTH   number of entries (power of 2, >= 2)
//   DEPTHW  pointer width, $clog2(DEPTH)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset; clears all entries and count
//   in_valid   writer presents data_in
//   in_ready   FIFO can accept a write (= !full)
//   data_in    write data
//   out_valid  data_out holds a valid word (= !empty, or bypass)
//   out_ready  reader accepts data_out this cycle
//   data_out   oldest entry; all zeros when empty (and no bypass)
//   count      occupied entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
// ----------------------------------------------------------------------------
module rv_shift_fifo_rd #(
  parameter int DATAW  = 8,
  parameter int DEPTH  = 4,
  parameter int DEPTHW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATAW-1:0]  data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATAW-1:0]  data_out,
  output logic [DEPTHW:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [DEPTHW:0] DEPTH_CNT = (DEPTHW+1)'(DEPTH);
  localparam logic [DEPTHW:0] CNT_ONE   = (DEPTHW+1)'(1);

  logic [DATAW-1:0] entries [DEPTH];
  logic [DEPTHW:0]  count_r;
  logic [DATAW-1:0] head_data;

  logic push;   // write handshake completes
  logic pop;    // read handshake completes
  logic store;  // write actually enters the shift register
  logic drain;  // read actually removes a stored entry

  // --------------------------------------------------------------------------
  // Status, all from the count register alone. in_ready deliberately ignores
  // out_ready: a pop while full does not open the write side in that cycle.
  // --------------------------------------------------------------------------
  assign count    = count_r;
  assign full     = (count_r == DEPTH_CNT);
  assign empty    = (count_r == '0);
  assign in_ready = !full;

  // --------------------------------------------------------------------------
  // Head select: entries[count-1], zero when empty. Comparing count against
  // each slot number avoids a wrapping count-1 index when count is zero.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    head_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_r == (DEPTHW+1)'(i + 1)) begin
        head_data = entries[i];
      end
    end
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

`ifdef RV_SHIFT_FIFO_BYPASS_EN
  // Fall-through: an empty FIFO forwards the incoming word directly. A word
  // consumed this way never touches storage or count.
  logic bypass;

  assign bypass    = empty & in_valid;
  assign out_valid = !empty | in_valid;
  assign data_out  = bypass ? data_in : head_data;
  assign store     = push & !(bypass & out_ready);
  assign drain     = pop & !bypass;
`else
  assign out_valid = !empty;
  assign data_out  = head_data;
  assign store     = push;
  assign drain     = pop;
`endif

  // --------------------------------------------------------------------------
  // Shift storage. On a write every slot moves up one; when a read happens
  // in the same cycle the oldest word is shifted to index count and simply
  // falls outside the occupied range.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage array is cleared on reset because data_out must
      // read as zero after reset; a plain RAM-style buffer would skip this.
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (store) begin
      // NOTE: non-blocking assignments let every slot read its neighbour's
      // old value, which is what makes this a shift rather than a smear.
      entries[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        entries[i] <= entries[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy. store implies !full and drain implies !empty, so count can
  // neither overflow nor underflow.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      case ({store, drain})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_shift_fifo_rd.sv
// ----------------------------------------------------------------------------
// tb_rv_shift_fifo_rd
//
// Directed bench for rv_shift_fifo_rd (DATAW = 8, DEPTH = 4). The stimulus
// process queues every word it expects the FIFO to accept; a monitor process
// pops that queue on every completed read handshake and compares data_out.
// Status outputs are checked directly against hand-computed values.
// Define RV_SHIFT_FIFO_BYPASS_EN for both bench and RTL to test fall-through.
// ----------------------------------------------------------------------------
module tb_rv_shift_fifo_rd;

  localparam int DATAW  = 8;
  localparam int DEPTH  = 4;
  localparam int DEPTHW = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATAW-1:0]  data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATAW-1:0]  data_out;
  logic [DEPTHW:0]   count;
  logic              full;
  logic              empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATAW-1:0] exp_q [$];

  rv_shift_fifo_rd #(
    .DATAW (DATAW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock: inputs change 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of writes and queue the word as an expected read.
  task automatic push_word(input logic [DATAW-1:0] d);
    in_valid = 1'b1;
    data_in  = d;
    exp_q.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard monitor: samples on the falling edge, away from updates.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_read", {24'd0, data_out}, 32'hDEAD);
        end else begin
          check("sb_read_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    tick();
    tick();
    reset = 1'b0;

    // ---- Reset state ------------------------------------------------------
    @(negedge clk);
    check("rst_count",     32'(count),     32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out",  32'(data_out),  32'h00);
    tick();

    // ---- Three pushes, reader stalled --------------------------------------
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    @(negedge clk);
    check("p3_count",     32'(count),     32'd3);
    check("p3_data_out",  32'(data_out),  32'h11);
    check("p3_out_valid", 32'(out_valid), 32'd1);
    check("p3_full",      32'(full),      32'd0);
    tick();

    // ---- Fill, hold a write while full, then drain -------------------------
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push_word(8'hA0 + 8'(i));
    end
    in_valid = 1'b1;
    data_in  = 8'hFF;          // must be refused: not queued
    @(negedge clk);
    check("full_full",     32'(full),     32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count",    32'(count),    32'd4);
    tick();
    @(negedge clk);
    check("full_hold_count", 32'(count),    32'd4);
    check("full_hold_head",  32'(data_out), 32'hA0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("drain_empty",     32'(empty),     32'd1);
    check("drain_count",     32'(count),     32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_data_out",  32'(data_out),  32'h00);
    tick();

    // ---- Simultaneous push and pop at count = 2 -----------------------------
    do_reset();
    push_word(8'h01);
    push_word(8'h02);
    in_valid  = 1'b1;
    data_in   = 8'h03;
    out_ready = 1'b1;
    exp_q.push_back(8'h03);
    @(negedge clk);
    check("pp_count_before", 32'(count),    32'd2);
    check("pp_head_before",  32'(data_out), 32'h01);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_count_after", 32'(count),    32'd2);
    check("pp_head_after",  32'(data_out), 32'h02);
    tick();
    out_ready = 1'b1;
    tick();                    // monitor expects 0x02
    @(negedge clk);
    check("pp_head_last", 32'(data_out), 32'h03);
    tick();                    // monitor expects 0x03
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_empty", 32'(empty), 32'd1);
    tick();

    // ---- Reader ready on an empty FIFO: no underflow ------------------------
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("uf_count",     32'(count),     32'd0);
      check("uf_out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    out_ready = 1'b0;

    // ---- Reset in the middle of traffic -------------------------------------
    push_word(8'h31);
    push_word(8'h32);
    push_word(8'h33);
    reset    = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'h99;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mrst_count",    32'(count),    32'd0);
    check("mrst_empty",    32'(empty),    32'd1);
    check("mrst_data_out", 32'(data_out), 32'h00);
    tick();
    push_word(8'h5A);
    @(negedge clk);
    check("mrst_push_data",  32'(data_out), 32'h5A);
    check("mrst_push_count", 32'(count),    32'd1);
    tick();
    out_ready = 1'b1;
    tick();                    // monitor expects 0x5A
    out_ready = 1'b0;

    // ---- Empty FIFO, write and read in the same cycle -----------------------
    do_reset();
    in_valid  = 1'b1;
    data_in   = 8'h77;
    out_ready = 1'b1;
    exp_q.push_back(8'h77);
    @(negedge clk);
    check("byp_count_c0", 32'(count), 32'd0);
`ifdef RV_SHIFT_FIFO_BYPASS_EN
    check("byp_out_valid_c0", 32'(out_valid), 32'd1);
    check("byp_data_out_c0",  32'(data_out),  32'h77);
`else
    check("byp_out_valid_c0", 32'(out_valid), 32'd0);
`endif
    tick();
    in_valid = 1'b0;
    @(negedge clk);
`ifdef RV_SHIFT_FIFO_BYPASS_EN
    check("byp_count_c1",     32'(count),     32'd0);
    check("byp_out_valid_c1", 32'(out_valid), 32'd0);
`else
    check("byp_count_c1",     32'(count),     32'd1);
    check("byp_data_out_c1",  32'(data_out),  32'h77);
`endif
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("byp_final_count", 32'(count), 32'd0);
    tick();

    // ---- Every expected read was observed -----------------------------------
    @(negedge clk);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
